// File: rtl/uart_frame_rx_if.sv
// Receiver-side bundle for uart_frame_rx: serial line, pop strobe,
// FIFO head, status and error pulses.
// Ports: RX, RD_EN (to receiver); DATA, VALID, BUSY, FRAME_ERR,
//        OVERRUN, PARITY_ERR (from receiver).
interface uart_frame_rx_if;
   logic       RX;
   logic       RD_EN;
   logic [7:0] DATA;
   logic       VALID;
   logic       BUSY;
   logic       FRAME_ERR;
   logic       OVERRUN;
   logic       PARITY_ERR;

   modport master (
      output RX,
      output RD_EN,
      input  DATA,
      input  VALID,
      input  BUSY,
      input  FRAME_ERR,
      input  OVERRUN,
      input  PARITY_ERR
   );

   modport slave (
      input  RX,
      input  RD_EN,
      output DATA,
      output VALID,
      output BUSY,
      output FRAME_ERR,
      output OVERRUN,
      output PARITY_ERR
   );
endinterface

// File: rtl/uart_frame_rx.sv
// Oversampling 8N1 UART receiver with a small FWFT receive FIFO.
// Ports: CLK, ARST_L (sync, active-low), bus (uart_frame_rx_if.slave).
// Optional even-parity bit: define UART_RX_PARITY_EN.
module uart_frame_rx #(
   parameter int BAUD_DIV   = 326,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          CLK,
   input  logic          ARST_L,
   uart_frame_rx_if.slave bus
);

   localparam int M  = OVERSAMPLE / 2;
   localparam int DW = $clog2(BAUD_DIV);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DIV - 1);
   localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_PRE    = SW'(M - 1);
   localparam logic [SW-1:0] S_MID    = SW'(M);
   localparam logic [SW-1:0] S_VOTE   = SW'(M + 1);
   localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] BREAK  = 3'd5;

   // line synchronizer; rx_d is the previous rx_s for edge detect
   logic rx_m;
   logic rx_s;
   logic rx_d;

   logic [2:0]    state;
   logic [DW-1:0] div;
   logic [SW-1:0] scnt;
   logic [1:0]    smp;
   logic [2:0]    bcnt;
   logic [7:0]    shreg;
   logic          push_req;
   logic [7:0]    push_byte;
   logic          frame_err_q;

`ifdef UART_RX_PARITY_EN
   logic          bad_par;
   logic          par_err_q;
`else
   localparam logic bad_par = 1'b0;
`endif

   logic tick;
   logic at_pre;
   logic at_mid;
   logic at_vote;
   logic vote;

   assign tick    = (state != IDLE) && (div == DIV_LAST);
   assign at_pre  = tick && (scnt == S_PRE);
   assign at_mid  = tick && (scnt == S_MID);
   assign at_vote = tick && (scnt == S_VOTE);

   // 2-of-3 majority; third sample is taken live at the vote tick
   assign vote = (smp[0] & smp[1]) |
                 (smp[0] & rx_s) |
                 (smp[1] & rx_s);

   always_ff @(posedge CLK) begin
      if (!ARST_L) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= bus.RX;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   always_ff @(posedge CLK) begin
      if (!ARST_L) begin
         state       <= IDLE;
         div         <= '0;
         scnt        <= '0;
         smp         <= '0;
         bcnt        <= '0;
         shreg       <= '0;
         push_req    <= 1'b0;
         push_byte   <= '0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bad_par     <= 1'b0;
         par_err_q   <= 1'b0;
`endif
      end else begin
         push_req    <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= 1'b0;
`endif
         // timebase is held at zero while idle so a
         // new frame always starts aligned to its edge
         if (state == IDLE) begin
            div  <= '0;
            scnt <= '0;
         end else begin
            div <= tick ? '0 : div + DW'(1);
            if (tick) begin
               scnt <= (scnt == S_LAST) ? '0
                     : scnt + SW'(1);
            end
         end

         if (at_pre) smp[0] <= rx_s;
         if (at_mid) smp[1] <= rx_s;

         unique case (state)
            IDLE: begin
               if (rx_d && !rx_s) begin
                  state <= START;
`ifdef UART_RX_PARITY_EN
                  bad_par <= 1'b0;
`endif
               end
            end
            START: begin
               if (at_mid && rx_s) begin
                  state <= IDLE;
               end else if (at_vote) begin
                  bcnt  <= '0;
                  state <= vote ? IDLE : DATA;
               end
            end
            DATA: begin
               if (at_vote) begin
                  shreg <= {vote, shreg[7:1]};
                  bcnt  <= bcnt + 3'd1;
                  if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (at_vote) begin
                  if (vote != ^shreg) begin
                     par_err_q <= 1'b1;
                     bad_par   <= 1'b1;
                  end
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               if (at_vote) begin
                  if (vote) begin
                     push_req  <= !bad_par;
                     push_byte <= shreg;
                     state     <= IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state       <= BREAK;
                  end
               end
            end
            BREAK: begin
               // a held-low line must go high before
               // another start edge can be seen
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW-1:0] rptr_n;
   logic [AW:0]   cnt;
   logic [AW:0]   cnt_n;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic          ovr;
   logic [7:0]    head_n;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          ovr_q;

   assign pop     = bus.RD_EN && (cnt != '0);
   assign full    = (cnt == FULL);
   assign push_ok = push_req && (!full || pop);
   assign ovr     = push_req && full && !pop;
   assign rptr_n  = pop ? rptr + AW'(1) : rptr;

   always_comb begin
      cnt_n = cnt;
      if (push_ok && !pop) begin
         cnt_n = cnt + (AW+1)'(1);
      end else if (!push_ok && pop) begin
         cnt_n = cnt - (AW+1)'(1);
      end
   end

   // head register looks ahead: when the new head is the slot
   // being written this edge, take the byte straight from the push
   always_comb begin
      head_n = mem[rptr_n];
      if (push_ok && (wptr == rptr_n)) begin
         head_n = push_byte;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok) mem[wptr] <= push_byte;
   end

   always_ff @(posedge CLK) begin
      if (!ARST_L) begin
         wptr    <= '0;
         rptr    <= '0;
         cnt     <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + AW'(1);
         rptr    <= rptr_n;
         cnt     <= cnt_n;
         valid_q <= (cnt_n != '0);
         data_q  <= (cnt_n != '0) ? head_n : '0;
         ovr_q   <= ovr;
      end
   end

   assign bus.DATA      = data_q;
   assign bus.VALID     = valid_q;
   assign bus.BUSY      = (state != IDLE);
   assign bus.FRAME_ERR = frame_err_q;
   assign bus.OVERRUN   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign bus.PARITY_ERR = par_err_q;
`else
   assign bus.PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed and random frames
// against a queue model of the receive FIFO and error pulse counts.
module tb_uart_frame_rx;

   localparam int B   = 2;
   localparam int OS  = 16;
   localparam int D   = 4;
   localparam int BIT = B * OS;
   localparam int M   = OS / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // clock index (from start-bit drive) at which the byte is pushed:
   // 2 sync flops, edge detect, vote at tick M+1 of the stop bit,
   // then push one cycle later
   localparam int PUSH_IDX = B * (OS * (NB - 1) + M + 1) + B - 1 + 4;

   logic CLK = 1'b0;
   logic ARST_L = 1'b0;

   always #5 CLK = ~CLK;

   uart_frame_rx_if bus ();

   uart_frame_rx #(
      .BAUD_DIV   (B),
      .OVERSAMPLE (OS),
      .FIFO_DEPTH (D)
   ) dut (
      .CLK    (CLK),
      .ARST_L (ARST_L),
      .bus    (bus)
   );

   int checks = 0;
   int failures = 0;
   int fe_n = 0;
   int ov_n = 0;
   int pe_n = 0;
   int exp_fe = 0;
   int exp_ov = 0;
   int exp_pe = 0;
   logic [7:0] q [$];

   always @(posedge CLK) begin
      #1;
      if (bus.FRAME_ERR === 1'b1) fe_n++;
      if (bus.OVERRUN === 1'b1) ov_n++;
      if (bus.PARITY_ERR === 1'b1) pe_n++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send(input logic [7:0] b, input logic stp,
                       input logic par, input bit pp);
      logic [10:0] fr;
`ifdef UART_RX_PARITY_EN
      fr = {stp, par, b, 1'b0};
`else
      fr = {par, stp, b, 1'b0};
`endif
      for (int i = 0; i < NB; i++) begin
         for (int j = 0; j < BIT; j++) begin
            @(negedge CLK);
            bus.RX = fr[i];
            bus.RD_EN = pp && ((i * BIT + j) == PUSH_IDX);
         end
      end
      @(negedge CLK);
      bus.RD_EN = 1'b0;
   endtask

   task automatic mpush(input logic [7:0] b);
      if (q.size() < D) q.push_back(b);
      else exp_ov++;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".valid"}, bus.VALID, q.size() != 0);
      if (q.size() != 0) chk({tag, ".data"}, bus.DATA, q[0]);
      chk({tag, ".fe"}, fe_n, exp_fe);
      chk({tag, ".ovr"}, ov_n, exp_ov);
      chk({tag, ".par"}, pe_n, exp_pe);
      chk({tag, ".busy"}, bus.BUSY, 1'b0);
   endtask

   task automatic pop(input string tag);
      @(negedge CLK);
      chk({tag, ".pv"}, bus.VALID, q.size() != 0);
      if (q.size() != 0) chk({tag, ".pd"}, bus.DATA, q[0]);
      bus.RD_EN = 1'b1;
      @(negedge CLK);
      bus.RD_EN = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   initial begin
      int busy_seen;
      int npop;
      logic [7:0] b;

      bus.RX = 1'b1;
      bus.RD_EN = 1'b0;
      ARST_L = 1'b0;
      idle(3);
      chk("rst.data", bus.DATA, 8'h00);
      chk("rst.valid", bus.VALID, 1'b0);
      chk("rst.busy", bus.BUSY, 1'b0);
      chk("rst.fe", bus.FRAME_ERR, 1'b0);
      chk("rst.ovr", bus.OVERRUN, 1'b0);
      chk("rst.par", bus.PARITY_ERR, 1'b0);
      ARST_L = 1'b1;
      busy_seen = 0;
      repeat (1000) begin
         @(negedge CLK);
         if (bus.BUSY !== 1'b0) busy_seen++;
      end
      chk("idle.busy", busy_seen, 0);

      // reset in the middle of a frame
      bus.RX = 1'b0;
      idle(3 * BIT);
      chk("mid.busy", bus.BUSY, 1'b1);
      bus.RX = 1'b1;
      ARST_L = 1'b0;
      idle(3);
      ARST_L = 1'b1;
      q.delete();
      idle(2 * BIT);
      chk_all("midrst");

      send(8'hA5, 1'b1, ^8'hA5, 1'b0);
      mpush(8'hA5);
      idle(8);
      chk_all("a5");
      pop("a5");
      chk_all("a5pop");
      pop("empty");
      chk_all("empty");

      bus.RX = 1'b0;
      idle(4);
      bus.RX = 1'b1;
      idle(2 * BIT);
      chk_all("glitch");

      send(8'h3C, 1'b0, ^8'h3C, 1'b0);
      idle(40 * BIT);
      bus.RX = 1'b1;
      exp_fe++;
      idle(2 * BIT);
      chk_all("frame");
      send(8'h11, 1'b1, ^8'h11, 1'b0);
      mpush(8'h11);
      idle(8);
      chk_all("after_fe");
      pop("after_fe");

      for (int k = 1; k <= 5; k++) begin
         b = 8'(k);
         send(b, 1'b1, ^b, 1'b0);
         mpush(b);
      end
      idle(8);
      chk_all("ovr");
      repeat (4) pop("ovr");
      chk_all("ovr_drain");

      for (int k = 0; k < 4; k++) begin
         b = 8'h21 + 8'(k);
         send(b, 1'b1, ^b, 1'b0);
         mpush(b);
      end
      send(8'h77, 1'b1, ^8'h77, 1'b1);
      void'(q.pop_front());
      q.push_back(8'h77);
      idle(8);
      chk_all("fullpop");
      repeat (4) pop("fullpop");
      chk_all("fp_drain");

`ifdef UART_RX_PARITY_EN
      send(8'h07, 1'b1, 1'b0, 1'b0);
      exp_pe++;
      idle(8);
      chk_all("parity");
`endif

      for (int r = 0; r < 12; r++) begin
         b = 8'($urandom);
         send(b, 1'b1, ^b, 1'b0);
         mpush(b);
         idle(4);
         chk_all("rnd");
         npop = $urandom_range(0, 2);
         repeat (npop) pop("rnd");
         idle($urandom_range(1, 50));
      end
      while (q.size() != 0) pop("drain");
      idle(2);
      chk_all("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
